// File: rtl/imm_enc_pkg.sv
// Shared types and defaults for the rotated-immediate encoder.
package imm_enc_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 8;
  localparam int DEF_ROT_W  = 4;
  localparam int ROT_MAX    = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/imm_rot_check.sv
// Combinational test of one rotation: rotate val left by 2*rot and report
// whether everything above the low IMM_W bits is zero.
module imm_rot_check
  import imm_enc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int ROT_W  = DEF_ROT_W
) (
  input  logic [DATA_W-1:0] val,
  input  logic [ROT_W-1:0]  rot,
  output logic              fits,
  output logic [IMM_W-1:0]  imm8
);

  logic [2*DATA_W-1:0] w_dbl;
  logic [2*DATA_W-1:0] w_shl;
  logic [DATA_W-1:0]   w_rol;
  logic [ROT_W:0]      w_amt;

  // Rotating the doubled word and keeping the top half gives a modulo-DATA_W ROL.
  assign w_amt = {rot, 1'b0};
  assign w_dbl = {val, val};
  assign w_shl = w_dbl << w_amt;
  assign w_rol = w_shl[2*DATA_W-1:DATA_W];

  assign fits = (w_rol[DATA_W-1:IMM_W] == '0);
  assign imm8 = w_rol[IMM_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative constant -> {rot, imm8} encoder, one rotation tested per clock.
// Define IMM_ENC_NEG_EN to also search ~value (MVN-style encodings, sets neg).
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int ROT_W  = DEF_ROT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_W-1:0]      value,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic                   neg,
  output logic [ROT_W+IMM_W-1:0] imm12
);

  state_t                 r_state;
  logic [DATA_W-1:0]      r_val;
  logic [ROT_W-1:0]       r_rot_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_valid;
  logic                   r_neg;
  logic [ROT_W+IMM_W-1:0] r_imm12;

  logic                   w_pos_fits;
  logic [IMM_W-1:0]       w_pos_imm8;
  logic                   w_neg_fits;
  logic [IMM_W-1:0]       w_neg_imm8;

  imm_rot_check #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .ROT_W  (ROT_W)
  ) u_pos_check (
    .val  (r_val),
    .rot  (r_rot_cnt),
    .fits (w_pos_fits),
    .imm8 (w_pos_imm8)
  );

`ifdef IMM_ENC_NEG_EN
  logic [DATA_W-1:0] w_val_inv;
  assign w_val_inv = ~r_val;

  imm_rot_check #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .ROT_W  (ROT_W)
  ) u_neg_check (
    .val  (w_val_inv),
    .rot  (r_rot_cnt),
    .fits (w_neg_fits),
    .imm8 (w_neg_imm8)
  );
`else
  assign w_neg_fits = 1'b0;
  assign w_neg_imm8 = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_val     <= '0;
      r_rot_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_neg     <= 1'b0;
      r_imm12   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_val     <= value;
            r_valid   <= 1'b0;
            r_neg     <= 1'b0;
            r_imm12   <= '0;
            r_rot_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= SEARCH;
          end
        end
        SEARCH: begin
          // Plain match beats inverted match at the same rotation.
          if (w_pos_fits) begin
            r_imm12 <= {r_rot_cnt, w_pos_imm8};
            r_valid <= 1'b1;
            r_neg   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (w_neg_fits) begin
            r_imm12 <= {r_rot_cnt, w_neg_imm8};
            r_valid <= 1'b1;
            r_neg   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_rot_cnt == ROT_W'(ROT_MAX)) begin
            r_imm12 <= '0;
            r_valid <= 1'b0;
            r_neg   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_rot_cnt <= r_rot_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign valid = r_valid;
  assign neg   = r_neg;
  assign imm12 = r_imm12;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: latency, result, round-trip decode,
// ignored starts and reset during a search.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        valid;
  logic        neg;
  logic [11:0] imm12;

  int n_assert = 0;
  int n_fail   = 0;

  imm_encoder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .neg   (neg),
    .imm12 (imm12)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: ROR({24'b0, imm8}, 2*rot), optionally inverted.
  function automatic logic [31:0] decode(input logic [11:0] f, input logic inv);
    logic [63:0] d;
    logic [5:0]  s;
    logic [31:0] r;
    d = {24'b0, f[7:0], 24'b0, f[7:0]};
    s = {1'b0, f[11:8], 1'b0};
    d = d >> s;
    r = d[31:0];
    return inv ? ~r : r;
  endfunction

  task automatic encode(input string tag, input logic [31:0] v, input int exp_lat,
                        input logic exp_valid, input logic exp_neg, input logic [11:0] exp_imm);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    value = v;
    start = 1'b1;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      value = $urandom();
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_valid"}, {31'b0, valid}, {31'b0, exp_valid});
    check({tag, "_neg"}, {31'b0, neg}, {31'b0, exp_neg});
    check({tag, "_imm12"}, {20'b0, imm12}, {20'b0, exp_imm});
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
    if (exp_valid) check({tag, "_roundtrip"}, decode(imm12, neg), v);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    $display("txn %s value=%08h lat=%0d valid=%0b neg=%0b imm12=%03h", tag, v, n, valid, neg, imm12);
  endtask

  initial begin
    int extra;
    reset = 1'b1;
    start = 1'b0;
    value = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_neg", {31'b0, neg}, 32'd0);
    check("rst_imm12", {20'b0, imm12}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    encode("x78",      32'h00000078, 2,  1'b1, 1'b0, 12'h078);
    encode("xFF000000", 32'hFF000000, 6,  1'b1, 1'b0, 12'h4FF);
    encode("xF000000F", 32'hF000000F, 4,  1'b1, 1'b0, 12'h2FF);
    encode("x3FC",     32'h000003FC, 17, 1'b1, 1'b0, 12'hFFF);
    encode("x101",     32'h00000101, 17, 1'b0, 1'b0, 12'h000);

    // Zero, with start held high through the busy and done cycles.
    value = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    value = 32'h00000101;
    check("zero_busy", {31'b0, busy}, 32'd1);
    check("zero_no_early_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("zero_done", {31'b0, done}, 32'd1);
    check("zero_valid", {31'b0, valid}, 32'd1);
    check("zero_imm12", {20'b0, imm12}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_busy_after", {31'b0, busy}, 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) extra++;
      @(posedge clk);
      #1;
    end
    check("ignored_start_no_done", extra, 32'd0);
    check("ignored_start_valid", {31'b0, valid}, 32'd1);
    check("ignored_start_imm12", {20'b0, imm12}, 32'd0);
    $display("txn zero_ignored_start extra_done=%0d valid=%0b imm12=%03h", extra, valid, imm12);

`ifdef IMM_ENC_NEG_EN
    encode("xFFFFFF87", 32'hFFFFFF87, 2,  1'b1, 1'b1, 12'h078);
`else
    encode("xFFFFFF87", 32'hFFFFFF87, 17, 1'b0, 1'b0, 12'h000);
`endif

    // Reset in the middle of a search.
    value = 32'h00000101;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_imm12", {20'b0, imm12}, 32'd0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) extra++;
      @(posedge clk);
      #1;
    end
    check("midrst_stays_idle", extra, 32'd0);
    $display("txn reset_mid_search busy=%0b valid=%0b imm12=%03h", busy, valid, imm12);

    encode("x78_after_rst", 32'h00000078, 2, 1'b1, 1'b0, 12'h078);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Iterative encoder that turns a 32-bit constant into the 12-bit rotated-immediate field {rot[3:0], imm8[7:0]}.
- Decoding rule it must satisfy: ExtImm = ROR({24'b0, imm8}, 2*rot).
- This is the inverse of the ExtendImm datapath. It is used by the instruction-assembly and constant-load path to decide whether a constant fits in an immediate operand.
- Tests one rotation per clock and uses a start/done handshake.

Parameters:
- DATA_W, 32: constant width. Must equal 2 * 2^ROT_W.
- IMM_W, 8: unrotated immediate width.
- ROT_W, 4: rotation field width. The rotation amount is 2*rot.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- value  in  DATA_W  constant to encode. Latched when start is accepted.
- busy  out  1  high while a search is in progress (SEARCH or DONE state).
- done  out  1  one-cycle pulse when the result is ready.
- valid  out  1  result is encodable. Held until the next accepted start.
- neg  out  1  result encodes ~value. Tied 0 unless IMM_ENC_NEG_EN is defined.
- imm12  out  12  {rot, imm8}. Held until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, valid=0, neg=0, imm12=12'h000, state=IDLE, rot_cnt=0.
- Reset wins over every other event, including a reset in the middle of a search. After reset the block is idle with all outputs cleared.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE with start=1: latch value into val_q, clear valid/neg/imm12 and rot_cnt, go to SEARCH. With start=0: stay.
  - SEARCH, match test: the rotation matches when ROL(val_q, 2*rot_cnt)[31:8] == 0.
  - SEARCH, on a match: imm12 <= {rot_cnt, ROL(val_q, 2*rot_cnt)[7:0]}, valid <= 1, go to DONE.
  - SEARCH, no match and rot_cnt == 15: valid <= 0, imm12 <= 0, go to DONE.
  - SEARCH, no match otherwise: rot_cnt <= rot_cnt + 1. The counter never wraps.
  - DONE: done=1 for exactly this cycle, then return to IDLE.
- The lowest matching rotation always wins, which gives a unique canonical encoding.
- Latency: a match at rotation r raises done r+2 clocks after the start edge. Minimum is 2, for r=0. An unencodable value raises done 17 clocks after the start edge.
- start while busy=1 is ignored and not queued.
- start in the same cycle as done: ignored, because the FSM is in DONE, not IDLE. The earliest new start is the cycle after done.
- Changes to value after the start edge have no effect.
- Zero: value 0 encodes as rot=0, imm8=0, valid=1.
- Rotation arithmetic is modulo 32. Shift amounts are 0..30, in even steps only.

Optional Feature:
- Macro: IMM_ENC_NEG_EN.
- Defined: each SEARCH cycle tests both val_q and ~val_q at rot_cnt.
  - The first rotation where either one matches wins.
  - At the same rotation, the plain value has priority over the inverted one.
  - An inverted match sets neg=1 and imm12 is built from ~val_q. This supports MVN-style constant loads.
  - Latency rules are unchanged.
- Undefined: only val_q is tested and neg stays 0.

Decomposition:
- Package imm_enc_pkg holds:
  - the state enum (IDLE/SEARCH/DONE);
  - DATA_W, IMM_W and ROT_W defaults;
  - ROT_MAX = 15.
- One combinational sub-module, imm_rot_check.
  - Inputs: val, rot.
  - Outputs: fits, imm8.
  - It is instantiated once, or twice when IMM_ENC_NEG_EN is defined.
- The FSM and the output registers stay in imm_encoder.

Test Plan:
- value=32'h00000078, start pulse -> done 2 clocks later, valid=1, imm12=12'h078, neg=0. This is the round-trip of ExtendImm(12'h78).
- value=32'hFF000000 -> done at +6, imm12=12'h4FF, valid=1. value=32'hF000000F -> done at +4, imm12=12'h2FF.
- value=32'h000003FC -> done at +17, imm12=12'hFFF. value=32'h00000101 -> done at +17, valid=0, imm12=12'h000.
- value=32'h0 -> done at +2, valid=1, imm12=12'h000. Also issue start during busy and in the DONE cycle -> ignored: no second done, result unchanged.
- With IMM_ENC_NEG_EN: value=32'hFFFFFF87 -> valid=1, neg=1, imm12=12'h078. Without the macro: valid=0, neg=0 at +17.
- Assert reset during SEARCH (e.g., 5 clocks into 32'h00000101) -> next cycle busy=0, done=0, valid=0, imm12=0. A fresh start of 32'h78 then completes normally at +2.
- Every run: decoding imm12 (and inverting when neg=1) must give back value.
